// File: rtl/mult_share_arbiter_pkg.sv
// mult_pkg: shared state encoding and widths for the shared multiplier block
package mult_pkg;
  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;
  localparam int MULT_W = 6;
  localparam int PROD_W = 12;
  localparam int CNT_W = 4;
endpackage

// File: rtl/mult_share_arbiter_if.sv
// mult_share_arbiter_if: operand and result handshakes for both requesters
interface mult_share_arbiter_if import mult_pkg::*; #(parameter int W = MULT_W);
  logic req0_valid, req0_ready, rsp0_valid, rsp0_ready;
  logic req1_valid, req1_ready, rsp1_valid, rsp1_ready;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [2*W-1:0] product;
  modport master (
    output req0_valid, req0_a, req0_b, rsp0_ready, req1_valid, req1_a, req1_b, rsp1_ready,
    input req0_ready, rsp0_valid, req1_ready, rsp1_valid, product
  );
  modport slave (
    input req0_valid, req0_a, req0_b, rsp0_ready, req1_valid, req1_a, req1_b, rsp1_ready,
    output req0_ready, rsp0_valid, req1_ready, rsp1_valid, product
  );
endinterface

// File: rtl/mult_share_arbiter_mult.sv
// unsigned_array_mult: combinational unsigned array multiplier, one adder row per multiplier bit
module unsigned_array_mult import mult_pkg::*; #(parameter int W = MULT_W) (
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-1:0] p
);
  logic [2*W-1:0] s [W+1];
  assign s[0] = '0;
  for (genvar i = 0; i < W; i++) begin : g_row
    assign s[i+1] = s[i] + ({{W{1'b0}}, a & {W{b[i]}}} << i);
  end
  assign p = s[W];
endmodule

// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter: round-robin sharing of one multi-cycle 6x6 multiplier between two requesters
module mult_share_arbiter import mult_pkg::*; #(
  parameter int W = MULT_W,
  parameter int SETTLE = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  mult_share_arbiter_if.slave bus,
  output logic                busy,
  output logic [15:0]         done_cnt
);
  state_t state;
  logic rr_ptr, gid, g, any;
  logic [W-1:0] a_r, b_r;
  logic [CNT_W-1:0] cnt;
  logic [2*W-1:0] m;
  assign any = bus.req0_valid | bus.req1_valid;
  assign g = (bus.req0_valid & bus.req1_valid) ? rr_ptr : bus.req1_valid;
  assign bus.req0_ready = rst_n & (state == IDLE) & any & ~g;
  assign bus.req1_ready = rst_n & (state == IDLE) & any & g;
  assign busy = state != IDLE;
  unsigned_array_mult #(.W(W)) u_mult (.a(a_r), .b(b_r), .p(m));
  // accept a granted operand, let the multiplier settle, then hold the product until consumed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      rr_ptr <= 1'b0;
      gid <= 1'b0;
      a_r <= '0;
      b_r <= '0;
      cnt <= '0;
      bus.product <= '0;
      bus.rsp0_valid <= 1'b0;
      bus.rsp1_valid <= 1'b0;
      done_cnt <= '0;
    end else begin
      case (state)
        IDLE: if (any) begin
          a_r <= g ? bus.req1_a : bus.req0_a;
          b_r <= g ? bus.req1_b : bus.req0_b;
          gid <= g;
          cnt <= CNT_W'(SETTLE - 1);
          state <= CALC;
        end
        CALC: if (cnt == '0) begin
          bus.product <= m;
          bus.rsp0_valid <= ~gid;
          bus.rsp1_valid <= gid;
          state <= RESP;
        end else cnt <= cnt - 1'b1;
        RESP: if (gid ? bus.rsp1_ready : bus.rsp0_ready) begin
          bus.rsp0_valid <= 1'b0;
          bus.rsp1_valid <= 1'b0;
          done_cnt <= done_cnt + 16'd1;
          rr_ptr <= ~gid;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mult_share_arbiter.sv
// tb_mult_share_arbiter: directed checks of arbitration, latency, backpressure and reset
module tb_mult_share_arbiter;
  import mult_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy1, busy4;
  logic [15:0] done1, done4;
  int checks = 0;
  int failures = 0;
  mult_share_arbiter_if i1 ();
  mult_share_arbiter_if i4 ();
  mult_share_arbiter #(.SETTLE(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(i1), .busy(busy1), .done_cnt(done1));
  mult_share_arbiter #(.SETTLE(4)) u4 (.clk(clk), .rst_n(rst_n), .bus(i4), .busy(busy4), .done_cnt(done4));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    {i1.req0_valid, i1.req1_valid, i1.rsp0_ready, i1.rsp1_ready} = '0;
    {i4.req0_valid, i4.req1_valid, i4.rsp0_ready, i4.rsp1_ready} = '0;
    {i1.req0_a, i1.req0_b, i1.req1_a, i1.req1_b} = '0;
    {i4.req0_a, i4.req0_b, i4.req1_a, i4.req1_b} = '0;
    i1.req0_valid = 1'b1; i1.req0_a = 6'd3; i1.req0_b = 6'd4;
    i1.req1_valid = 1'b1; i1.req1_a = 6'd10; i1.req1_b = 6'd6;
    tick(); tick();
    chk("rst_ready0", i1.req0_ready, 0);
    chk("rst_ready1", i1.req1_ready, 0);
    chk("rst_rsp", {i1.rsp0_valid, i1.rsp1_valid}, 0);
    chk("rst_product", i1.product, 0);
    chk("rst_busy", busy1, 0);
    chk("rst_done", done1, 0);
    rst_n = 1'b1;
    #1;
    chk("cont_ready0", i1.req0_ready, 1);
    chk("cont_ready1", i1.req1_ready, 0);
    tick();
    chk("cont_busy", busy1, 1);
    chk("cont_ready_calc", {i1.req0_ready, i1.req1_ready}, 0);
    i1.req0_valid = 1'b0;
    tick();
    chk("cont_rsp0", i1.rsp0_valid, 1);
    chk("cont_rsp1_idle", i1.rsp1_valid, 0);
    chk("cont_prod0", i1.product, 12);
    chk("cont_ready1_resp", i1.req1_ready, 0);
    i1.rsp0_ready = 1'b1;
    tick();
    i1.rsp0_ready = 1'b0;
    chk("cont_done1", done1, 1);
    chk("cont_busy_idle", busy1, 0);
    chk("cont_rsp0_drop", i1.rsp0_valid, 0);
    chk("cont_ready1_now", i1.req1_ready, 1);
    tick();
    i1.req1_valid = 1'b0;
    tick();
    chk("cont_rsp1", i1.rsp1_valid, 1);
    chk("cont_rsp0_off", i1.rsp0_valid, 0);
    chk("cont_prod1", i1.product, 60);
    i1.rsp1_ready = 1'b1;
    tick();
    i1.rsp1_ready = 1'b0;
    chk("cont_done2", done1, 2);
    i1.req0_valid = 1'b1; i1.req0_a = 6'd5; i1.req0_b = 6'd7;
    #1;
    chk("single_ready0", i1.req0_ready, 1);
    tick();
    i1.req0_valid = 1'b0;
    chk("single_rsp_early", i1.rsp0_valid, 0);
    tick();
    chk("single_rsp0", i1.rsp0_valid, 1);
    chk("single_prod", i1.product, 35);
    i1.rsp0_ready = 1'b1;
    tick();
    i1.rsp0_ready = 1'b0;
    chk("single_done", done1, 3);
    chk("single_busy", busy1, 0);
    i1.req1_valid = 1'b1; i1.req1_a = 6'd63; i1.req1_b = 6'd63;
    tick();
    i1.req1_valid = 1'b0;
    chk("max_rsp0_calc", i1.rsp0_valid, 0);
    tick();
    chk("max_rsp1", i1.rsp1_valid, 1);
    chk("max_rsp0", i1.rsp0_valid, 0);
    chk("max_prod", i1.product, 3969);
    i1.rsp1_ready = 1'b1;
    tick();
    i1.rsp1_ready = 1'b0;
    chk("max_done", done1, 4);
    chk("max_rsp0_after", i1.rsp0_valid, 0);
    i1.req0_valid = 1'b1; i1.req0_a = 6'd2; i1.req0_b = 6'd9;
    tick();
    i1.req0_valid = 1'b0;
    tick();
    i1.req1_valid = 1'b1; i1.req1_a = 6'd1; i1.req1_b = 6'd1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("bp_rsp0_%0d", k), i1.rsp0_valid, 1);
      chk($sformatf("bp_prod_%0d", k), i1.product, 18);
      chk($sformatf("bp_ready1_%0d", k), i1.req1_ready, 0);
    end
    i1.rsp0_ready = 1'b1;
    tick();
    i1.rsp0_ready = 1'b0;
    chk("bp_done", done1, 5);
    chk("bp_rsp0_drop", i1.rsp0_valid, 0);
    chk("bp_ready1", i1.req1_ready, 1);
    tick();
    i1.req1_valid = 1'b0;
    tick();
    chk("bp_prod1", i1.product, 1);
    chk("bp_rsp1", i1.rsp1_valid, 1);
    i1.rsp1_ready = 1'b1;
    tick();
    i1.rsp1_ready = 1'b0;
    chk("bp_done2", done1, 6);
    i4.req0_valid = 1'b1; i4.req0_a = 6'd0; i4.req0_b = 6'd45;
    tick();
    i4.req0_valid = 1'b0;
    for (int k = 1; k < 4; k++) begin
      tick();
      chk($sformatf("s4a_wait_%0d", k), i4.rsp0_valid, 0);
    end
    tick();
    chk("s4a_rsp0", i4.rsp0_valid, 1);
    chk("s4a_prod", i4.product, 0);
    i4.rsp0_ready = 1'b1;
    tick();
    i4.rsp0_ready = 1'b0;
    chk("s4a_done", done4, 1);
    i4.req1_valid = 1'b1; i4.req1_a = 6'd1; i4.req1_b = 6'd63;
    tick();
    i4.req1_valid = 1'b0;
    for (int k = 1; k < 4; k++) begin
      tick();
      chk($sformatf("s4b_wait_%0d", k), i4.rsp1_valid, 0);
    end
    tick();
    chk("s4b_rsp1", i4.rsp1_valid, 1);
    chk("s4b_prod", i4.product, 63);
    i4.rsp1_ready = 1'b1;
    tick();
    i4.rsp1_ready = 1'b0;
    chk("s4b_done", done4, 2);
    i4.req0_valid = 1'b1; i4.req0_a = 6'd3; i4.req0_b = 6'd3;
    tick();
    i4.req0_valid = 1'b0;
    tick();
    chk("mid_busy_pre", busy4, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_busy", busy4, 0);
    chk("mid_done4", done4, 0);
    chk("mid_done1", done1, 0);
    chk("mid_prod", i4.product, 0);
    chk("mid_rsp", {i4.rsp0_valid, i4.rsp1_valid}, 0);
    i4.req0_valid = 1'b1; i4.req0_a = 6'd2; i4.req0_b = 6'd3;
    i4.req1_valid = 1'b1; i4.req1_a = 6'd4; i4.req1_b = 6'd5;
    tick();
    chk("mid_ready_held", {i4.req0_ready, i4.req1_ready}, 0);
    rst_n = 1'b1;
    #1;
    chk("post_ready0", i4.req0_ready, 1);
    chk("post_ready1", i4.req1_ready, 0);
    tick();
    i4.req0_valid = 1'b0;
    repeat (4) tick();
    chk("post_rsp0", i4.rsp0_valid, 1);
    chk("post_prod", i4.product, 6);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
